sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single sdram_controller user port (fpga_* signals) among NUM_REQ requesters.
//  Sits between client blocks (test FSMs, video/DMA engines) and sdram_controller, in the fpga_clk (166 MHz) domain.
//  Latches one winner's command, holds fpga_req until fpga_ack, then returns read data or write completion to that winner only.
// PARAMETERS
//  NUM_REQ          4     number of requesters (2..8)
//  FPGA_ADDR_WIDTH  23    address width, {bank,row,col}
//  FPGA_DATA_WIDTH  32    data width
//  TIMEOUT_CYCLES   4096  ack watchdog limit (used only with SDRAM_ARB_TIMEOUT_EN)
// PORTS
//  fpga_clk     in   1                  system clock
//  fpga_reset   in   1                  synchronous, active-high reset
//  req_valid    in   NUM_REQ            per-requester command pending; held until req_ready
//  req_we       in   NUM_REQ            1 = write, 0 = read
//  req_addr     in   NUM_REQ*AW         packed addresses, requester i at [i*AW +: AW]
//  req_wdata    in   NUM_REQ*DW         packed write data
//  req_ready    out  NUM_REQ            one-cycle one-hot pulse: command of requester i accepted
//  resp_valid   out  NUM_REQ            one-cycle one-hot pulse: transaction of requester i finished
//  resp_rdata   out  DW                 read data, valid with resp_valid
//  resp_err     out  1                  timeout flag, valid with resp_valid (0 when macro undefined)
//  fpga_addr    out  AW                 to controller
//  fpga_wr_en   out  1                  to controller
//  fpga_wr_data out  DW                 to controller
//  fpga_rd_en   out  1                  to controller
//  fpga_req     out  1                  to controller, level request
//  fpga_ack     in   1                  from controller, one-cycle completion pulse
//  fpga_rd_data in   DW                 from controller, valid in the fpga_ack cycle of a read
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_valid, resp_rdata, resp_err, fpga_*). Reset mid-transaction drops fpga_req next edge; no resp issued.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if any req_valid, pick first set bit at or after rr_ptr (circular); register addr/we/wdata into fpga_*,
//      fpga_wr_en=we, fpga_rd_en=~we, fpga_req=1, req_ready[win]=1 for that cycle, grant_id<=win, rr_ptr<=win+1 mod NUM_REQ; go BUSY.
//    BUSY: hold all fpga_* stable; on fpga_ack: fpga_req/wr_en/rd_en <=0, resp_rdata<=fpga_rd_data (reads only, else unchanged), go RESP.
//    RESP: resp_valid[grant_id]=1 for exactly one cycle; go IDLE. Earliest next grant is the cycle after RESP.
//  - Latency: req_valid seen at edge N -> req_ready and fpga_req high after edge N; ack at edge M -> resp_valid high after edge M+1.
//  - Requests arriving while BUSY/RESP wait; req_valid deasserted before grant is simply skipped (no latching of unasserted requests).
//  - rr_ptr wraps NUM_REQ-1 -> 0; no starvation: each pending requester served within NUM_REQ grants.
//  - fpga_ack in IDLE or RESP is ignored. fpga_req never asserted for more than one outstanding command.
// CONFIGURATION
//  SDRAM_ARB_TIMEOUT_EN defined: BUSY cycle counter; if TIMEOUT_CYCLES elapse without fpga_ack, drop fpga_req, go RESP with resp_err=1, resp_rdata=0;
//   counter cleared on entry to BUSY. Late ack after abort ignored.
//  Undefined: no counter, BUSY waits indefinitely, resp_err tied 0.
// STRUCTURE
//  Package sdram_arb_pkg: state encoding localparams (IDLE/BUSY/RESP), PTR_W=$clog2(NUM_REQ).
//  Sub-module rr_pick (combinational): inputs req vector + rr_ptr, outputs win index and any_req; rest in top.
// TESTING
//  1 Single read: req_valid=0001, addr=0x000401, ack 6 cycles later with rd_data=0x0000FF01 -> req_ready=0001 one cycle, resp_valid=0001, resp_rdata=0x0000FF01.
//  2 All four request continuously, writes, ack latency 3 -> grant order 0,1,2,3,0; each req_ready one-hot; fpga_req drops between transactions.
//  3 rr_ptr=3, req_valid=1001 -> requester 3 wins, then 0; rr_ptr ends at 1.
//  4 fpga_ack pulsed while IDLE -> no resp_valid, state stays IDLE.
//  5 Reset asserted during BUSY -> next edge all outputs 0, rr_ptr=0; later request granted to requester 0 first.
//  6 SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> after 16 BUSY cycles resp_valid with resp_err=1; late ack ignored.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM user-port arbiter.
// The optional ack watchdog is enabled in the top by defining SDRAM_ARB_TIMEOUT_EN.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int NUM_REQ_DEFAULT = 4;

   // Round-robin pointer width; a two-requester arbiter still needs one bit.
   function automatic int ptr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int PTR_W = ptr_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, circularly.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   win,
   output logic               any_req
);

   int idx;

   // Scanning from the farthest offset down lets the nearest request overwrite the result last.
   always_comb begin
      win     = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx]) begin
            win     = idx[PTR_W-1:0];
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the sdram_controller user port among NUM_REQ clients.
// Define SDRAM_ARB_TIMEOUT_EN to add an ack watchdog that aborts a stuck transaction with resp_err.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int FPGA_ADDR_WIDTH = 23,
   parameter int FPGA_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic                                fpga_clk,
   input  logic                                fpga_reset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0]                  req_we,
   input  logic [NUM_REQ*FPGA_ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*FPGA_DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic [NUM_REQ-1:0]                  resp_valid,
   output logic [FPGA_DATA_WIDTH-1:0]          resp_rdata,
   output logic                                resp_err,
   output logic [FPGA_ADDR_WIDTH-1:0]          fpga_addr,
   output logic                                fpga_wr_en,
   output logic [FPGA_DATA_WIDTH-1:0]          fpga_wr_data,
   output logic                                fpga_rd_en,
   output logic                                fpga_req,
   input  logic                                fpga_ack,
   input  logic [FPGA_DATA_WIDTH-1:0]          fpga_rd_data
);

   localparam int AW    = FPGA_ADDR_WIDTH;
   localparam int DW    = FPGA_DATA_WIDTH;
   localparam int PW    = ptr_width(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_t       state;
   arb_state_t       next_state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    grant_id;
   logic [PW-1:0]    win;
   logic             any_req;
   logic             timeout_hit;
   logic             err_flag;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PW)
   ) u_rr_pick (
      .req     (req_valid),
      .rr_ptr  (rr_ptr),
      .win     (win),
      .any_req (any_req)
   );

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] busy_cnt;

   // Counts cycles spent in BUSY; outside BUSY it sits at zero so every grant starts fresh.
   always_ff @(posedge fpga_clk) begin
      if (fpga_reset) begin
         busy_cnt <= '0;
      end else if (state != BUSY) begin
         busy_cnt <= '0;
      end else begin
         busy_cnt <= busy_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge fpga_clk) begin
      if (fpga_reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = BUSY;
         BUSY:    if (fpga_ack || timeout_hit) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Command/response registers; an ack always takes precedence over a same-cycle timeout.
   always_ff @(posedge fpga_clk) begin
      if (fpga_reset) begin
         req_ready    <= '0;
         resp_valid   <= '0;
         resp_rdata   <= '0;
         resp_err     <= 1'b0;
         fpga_addr    <= '0;
         fpga_wr_en   <= 1'b0;
         fpga_wr_data <= '0;
         fpga_rd_en   <= 1'b0;
         fpga_req     <= 1'b0;
         rr_ptr       <= '0;
         grant_id     <= '0;
         err_flag     <= 1'b0;
      end else begin
         req_ready  <= '0;
         resp_valid <= '0;
         resp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  fpga_addr    <= req_addr[int'(win)*AW +: AW];
                  fpga_wr_data <= req_wdata[int'(win)*DW +: DW];
                  fpga_wr_en   <= req_we[win];
                  fpga_rd_en   <= ~req_we[win];
                  fpga_req     <= 1'b1;
                  req_ready    <= ONE_HOT0 << win;
                  grant_id     <= win;
                  if (int'(win) == NUM_REQ - 1) begin
                     rr_ptr <= '0;
                  end else begin
                     rr_ptr <= win + 1'b1;
                  end
               end
            end
            BUSY: begin
               if (fpga_ack) begin
                  fpga_req   <= 1'b0;
                  fpga_wr_en <= 1'b0;
                  fpga_rd_en <= 1'b0;
                  if (fpga_rd_en) begin
                     resp_rdata <= fpga_rd_data;
                  end
               end else if (timeout_hit) begin
                  fpga_req   <= 1'b0;
                  fpga_wr_en <= 1'b0;
                  fpga_rd_en <= 1'b0;
                  resp_rdata <= '0;
                  err_flag   <= 1'b1;
               end
            end
            RESP: begin
               resp_valid <= ONE_HOT0 << grant_id;
               resp_err   <= err_flag;
               err_flag   <= 1'b0;
            end
            default: begin
               err_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter; covers the SDRAM_ARB_TIMEOUT_EN build when defined.
module tb_sdram_port_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 23;
   localparam int DW      = 32;
   localparam int TO      = 16;

   logic                   fpga_clk;
   logic                   fpga_reset;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_we;
   logic [NUM_REQ*AW-1:0]  req_addr;
   logic [NUM_REQ*DW-1:0]  req_wdata;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     resp_valid;
   logic [DW-1:0]          resp_rdata;
   logic                   resp_err;
   logic [AW-1:0]          fpga_addr;
   logic                   fpga_wr_en;
   logic [DW-1:0]          fpga_wr_data;
   logic                   fpga_rd_en;
   logic                   fpga_req;
   logic                   fpga_ack;
   logic [DW-1:0]          fpga_rd_data;

   logic [AW-1:0]          ta [NUM_REQ];
   logic [DW-1:0]          tw [NUM_REQ];
   logic [DW-1:0]          exp_rdata;
   int                     checks;
   int                     failures;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign req_addr[g*AW +: AW]  = ta[g];
      assign req_wdata[g*DW +: DW] = tw[g];
   end

   sdram_port_arbiter #(
      .NUM_REQ         (NUM_REQ),
      .FPGA_ADDR_WIDTH (AW),
      .FPGA_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .fpga_clk     (fpga_clk),
      .fpga_reset   (fpga_reset),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .fpga_addr    (fpga_addr),
      .fpga_wr_en   (fpga_wr_en),
      .fpga_wr_data (fpga_wr_data),
      .fpga_rd_en   (fpga_rd_en),
      .fpga_req     (fpga_req),
      .fpga_ack     (fpga_ack),
      .fpga_rd_data (fpga_rd_data)
   );

   initial fpga_clk = 1'b0;
   always #5 fpga_clk = ~fpga_clk;

   task automatic tick();
      @(posedge fpga_clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, ".req_ready"}, 64'(req_ready), 64'd0);
      check_output({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
      check_output({tag, ".resp_rdata"}, 64'(resp_rdata), 64'd0);
      check_output({tag, ".resp_err"}, 64'(resp_err), 64'd0);
      check_output({tag, ".fpga_ctl"}, 64'({fpga_req, fpga_wr_en, fpga_rd_en}), 64'd0);
      check_output({tag, ".fpga_addr"}, 64'(fpga_addr), 64'd0);
      check_output({tag, ".fpga_wr_data"}, 64'(fpga_wr_data), 64'd0);
   endtask

   // One full transaction: wait (bounded) for a grant, check the command, ack after 'delay' cycles, check response.
   task automatic apply_stimulus(input string tag, input int exp, input int delay,
                                 input logic [DW-1:0] rdv, input logic clear);
      logic [NUM_REQ-1:0] oh;
      logic               is_wr;
      oh    = 4'b0001 << exp;
      is_wr = req_we[exp];
      for (int c = 0; c < 12; c++) begin
         tick();
         if (req_ready != '0) break;
      end
      check_output({tag, ".ready"}, 64'(req_ready), 64'(oh));
      check_output({tag, ".req"}, 64'(fpga_req), 64'd1);
      check_output({tag, ".addr"}, 64'(fpga_addr), 64'(ta[exp]));
      check_output({tag, ".we_re"}, 64'({fpga_wr_en, fpga_rd_en}), 64'({is_wr, ~is_wr}));
      if (is_wr) check_output({tag, ".wdata"}, 64'(fpga_wr_data), 64'(tw[exp]));
      if (clear) req_valid[exp] = 1'b0;
      for (int k = 1; k < delay; k++) begin
         tick();
         check_output({tag, ".hold"}, 64'({fpga_req, req_ready}), 64'({1'b1, 4'b0000}));
      end
      fpga_ack     = 1'b1;
      fpga_rd_data = rdv;
      tick();
      fpga_ack     = 1'b0;
      fpga_rd_data = 32'hBAD0_BAD0;
      check_output({tag, ".drop"}, 64'({fpga_req, fpga_wr_en, fpga_rd_en, resp_valid}), 64'd0);
      if (!is_wr) exp_rdata = rdv;
      tick();
      check_output({tag, ".resp_valid"}, 64'(resp_valid), 64'(oh));
      check_output({tag, ".resp_rdata"}, 64'(resp_rdata), 64'(exp_rdata));
      check_output({tag, ".resp_err"}, 64'(resp_err), 64'd0);
   endtask

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks       = 0;
      failures     = 0;
      exp_rdata    = '0;
      fpga_reset   = 1'b1;
      req_valid    = '0;
      req_we       = '0;
      fpga_ack     = 1'b0;
      fpga_rd_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ta[i] = AW'(23'h000100 + i * 16);
         tw[i] = 32'hA000_0000 + i;
      end

      tick();
      tick();
      check_all_zero("reset");
      fpga_reset = 1'b0;

      // Single read from requester 0, ack six cycles after the grant.
      ta[0]     = 23'h000401;
      req_we    = 4'b0000;
      req_valid = 4'b0001;
      apply_stimulus("single_rd", 0, 6, 32'h0000_FF01, 1'b1);

      // Stray ack while idle must produce nothing and leave the read data alone.
      fpga_ack     = 1'b1;
      fpga_rd_data = 32'hDEAD_BEEF;
      tick();
      fpga_ack = 1'b0;
      tick();
      check_output("idle_ack.resp_valid", 64'(resp_valid), 64'd0);
      check_output("idle_ack.req", 64'(fpga_req), 64'd0);
      check_output("idle_ack.rdata", 64'(resp_rdata), 64'(exp_rdata));
      req_valid = 4'b0010;
      apply_stimulus("idle_ack.grant1", 1, 2, 32'h0000_1111, 1'b1);

      fpga_reset = 1'b1;
      tick();
      fpga_reset = 1'b0;
      exp_rdata  = '0;
      check_all_zero("reset2");

      // Four continuous writers served strictly in rotation.
      ta[0]     = 23'h000100;
      req_we    = 4'b1111;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         apply_stimulus($sformatf("rr%0d", k), k % 4, 3, 32'h0, 1'b0);
      end
      req_valid = 4'b0000;

      // Pointer at 3 with requesters 3 and 0 pending, then all pending to expose the final pointer.
      req_we    = 4'b0000;
      req_valid = 4'b0100;
      apply_stimulus("ptr_to3", 2, 2, 32'h0000_0033, 1'b1);
      req_valid = 4'b1001;
      apply_stimulus("wrap3", 3, 2, 32'h0000_0303, 1'b1);
      apply_stimulus("wrap0", 0, 2, 32'h0000_0404, 1'b1);
      req_valid = 4'b1111;
      apply_stimulus("ptr_is1", 1, 2, 32'h0000_0505, 1'b0);
      req_valid = 4'b0000;

      // Reset while BUSY, then confirm the pointer restarted at requester 0.
      req_valid = 4'b0100;
      tick();
      check_output("rst_busy.ready", 64'(req_ready), 64'h4);
      req_valid = 4'b0000;
      tick();
      tick();
      fpga_reset = 1'b1;
      tick();
      fpga_reset = 1'b0;
      exp_rdata  = '0;
      check_all_zero("rst_busy");
      req_valid = 4'b1111;
      apply_stimulus("rst_busy.first", 0, 2, 32'h0000_0606, 1'b1);
      req_valid = 4'b0000;

      req_valid = 4'b0001;
      tick();
      check_output("noack.ready", 64'(req_ready), 64'h1);
      req_valid = 4'b0000;
`ifdef SDRAM_ARB_TIMEOUT_EN
      for (int k = 1; k < TO; k++) tick();
      check_output("timeout.before", 64'(fpga_req), 64'd1);
      tick();
      check_output("timeout.drop", 64'({fpga_req, resp_valid}), 64'd0);
      tick();
      check_output("timeout.resp_valid", 64'(resp_valid), 64'h1);
      check_output("timeout.resp_err", 64'(resp_err), 64'd1);
      check_output("timeout.rdata", 64'(resp_rdata), 64'd0);
      fpga_ack     = 1'b1;
      fpga_rd_data = 32'h1234_5678;
      tick();
      fpga_ack = 1'b0;
      tick();
      tick();
      check_output("late_ack.resp_valid", 64'(resp_valid), 64'd0);
      check_output("late_ack.rdata", 64'(resp_rdata), 64'd0);
      check_output("late_ack.req", 64'(fpga_req), 64'd0);
`else
      for (int k = 0; k < 40; k++) tick();
      check_output("noack.hold", 64'({fpga_req, resp_valid}), 64'({1'b1, 4'b0000}));
      fpga_ack     = 1'b1;
      fpga_rd_data = 32'h0000_0077;
      tick();
      fpga_ack = 1'b0;
      tick();
      check_output("noack.resp_valid", 64'(resp_valid), 64'h1);
      check_output("noack.resp_err", 64'(resp_err), 64'd0);
      check_output("noack.rdata", 64'(resp_rdata), 64'h77);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
